ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_ctrl_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/ram_arbiter.sv | 147 ++++++++++++++
 tb/tb_ram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// ============================================================================
// ram_ctrl_pkg : RAM command opcodes and arbiter FSM state type. Rev 1.0
// ============================================================================
`default_nettype none

package ram_ctrl_pkg;

  localparam logic [1:0] c_op_waddr = 2'b00;
  localparam logic [1:0] c_op_wdata = 2'b01;
  localparam logic [1:0] c_op_raddr = 2'b10;
  localparam logic [1:0] c_op_rdata = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_WAIT_RD = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : two-way round-robin grant; last grant resets to requester 1. Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic r_last;

  // On contention favour whichever requester did not win last time.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = r_last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (update && (grant != 2'b00)) begin
      r_last <= grant[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// ram_arbiter : arbitrates two requesters onto a command-word RAM port. Rev 1.0
// ============================================================================
`default_nettype none

module ram_arbiter #(
  parameter int RD_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_we,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_we,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_rdata,
  output logic       rsp0_err,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_rdata,
  output logic       rsp1_err,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid
);

  import ram_ctrl_pkg::*;

  localparam logic [7:0] c_cnt_last = 8'(RD_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_id;
  logic        r_we;
  logic [7:0]  r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic        r_err;
  logic [7:0]  r_cnt;
  logic [1:0]  w_grant;
  logic        w_accept;
  logic        w_timeout;

  assign w_accept  = (r_state == ST_IDLE) && (req0_valid || req1_valid);
  assign w_timeout = (r_cnt == c_cnt_last);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .update (w_accept),
    .grant  (w_grant)
  );

  always_comb begin
    w_next       = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    ram_din      = 10'h000;
    ram_rx_valid = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req0_ready = w_grant[0];
        req1_ready = w_grant[1];
        if (w_accept) w_next = ST_ADDR;
      end
      ST_ADDR: begin
        ram_din      = {(r_we ? c_op_waddr : c_op_raddr), r_addr};
        ram_rx_valid = 1'b1;
        w_next       = ST_DATA;
      end
      ST_DATA: begin
        ram_rx_valid = 1'b1;
        if (r_we) begin
          ram_din = {c_op_wdata, r_wdata};
          w_next  = ST_RESP;
        end else begin
          ram_din = {c_op_rdata, 8'h00};
          w_next  = ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        if (ram_tx_valid || w_timeout) w_next = ST_RESP;
      end
      ST_RESP: begin
        rsp0_valid = ~r_id;
        rsp1_valid = r_id;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Response payload is only visible on the pulsing requester's port.
  assign rsp0_rdata = rsp0_valid ? r_rdata : 8'h00;
  assign rsp1_rdata = rsp1_valid ? r_rdata : 8'h00;
  assign rsp0_err   = rsp0_valid & r_err;
  assign rsp1_err   = rsp1_valid & r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
      r_err   <= 1'b0;
      r_cnt   <= 8'h00;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id    <= w_grant[1];
            r_we    <= w_grant[1] ? req1_we    : req0_we;
            r_addr  <= w_grant[1] ? req1_addr  : req0_addr;
            r_wdata <= w_grant[1] ? req1_wdata : req0_wdata;
          end
        end
        ST_DATA: begin
          r_cnt   <= 8'h00;
          r_rdata <= 8'h00;
          r_err   <= 1'b0;
        end
        ST_WAIT_RD: begin
          r_cnt <= r_cnt + 8'h01;
          // Data arriving on the final wait cycle still wins over the timeout.
          if (ram_tx_valid) r_rdata <= ram_dout;
          else if (w_timeout) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// tb_ram_arbiter : transaction-level model plus directed vectors. Rev 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

  localparam int RD_TIMEOUT = 16;
  localparam int NCYC       = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_we;
  logic [7:0] req0_addr, req0_wdata;
  logic       req1_valid, req1_ready, req1_we;
  logic [7:0] req1_addr, req1_wdata;
  logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;

  always #5 clk = ~clk;

  ram_arbiter #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Observed events, used by the hand-computed literal checks.
  int         acc_port[$], acc_cyc[$];
  int         rsp_port[$], rsp_cyc[$];
  logic [7:0] rsp_data[$];
  logic       rsp_errq[$];
  logic [9:0] din_log[$];

  // Expected per-cycle outputs scheduled by the model.
  bit         e_cv[NCYC];
  logic [9:0] e_din[NCYC];
  bit         e_rv[NCYC];
  bit         e_rp[NCYC];
  logic [7:0] e_rd[NCYC];
  bit         e_re[NCYC];

  int         m_free   = 0;
  int         m_wstart = 0;
  bit         m_wait   = 1'b0;
  bit         m_last   = 1'b1;
  bit         m_g, m_we, er0, er1;
  logic [7:0] m_a, m_d;
  logic [9:0] exp_cmd;
  logic [19:0] exp_rsp;

  // RAM model state
  bit         ram_mode = 1'b0;
  bit         spur_tv  = 1'b0;
  logic [7:0] spur_dout = 8'h00;
  bit         ram_pend = 1'b0;
  logic [7:0] ram_waddr = 8'h00, ram_raddr = 8'h00;
  logic [7:0] ram_mem[256];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void sched_rsp(input int c, input bit p, input logic [7:0] d, input bit e);
    e_rv[c] = 1'b1; e_rp[c] = p; e_rd[c] = d; e_re[c] = e;
    m_free  = c + 1;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
    ram_tx_valid = 1'b0;
    ram_dout     = 8'h00;
    forever begin
      @(posedge clk); #1;
      ram_tx_valid = ram_pend | spur_tv;
      ram_dout     = ram_pend ? ram_mem[ram_raddr] : (spur_tv ? spur_dout : 8'h00);
      ram_pend     = 1'b0;
      @(negedge clk);
      if (ram_rx_valid) begin
        case (ram_din[9:8])
          2'b00: ram_waddr = ram_din[7:0];
          2'b01: ram_mem[ram_waddr] = ram_din[7:0];
          2'b10: ram_raddr = ram_din[7:0];
          default: ram_pend = ram_mode;
        endcase
      end
    end
  end

  // Model + compare, once per cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (req0_valid && req0_ready) begin acc_port.push_back(0); acc_cyc.push_back(cyc); end
      if (req1_valid && req1_ready) begin acc_port.push_back(1); acc_cyc.push_back(cyc); end
      if (ram_rx_valid) din_log.push_back(ram_din);
      if (rsp0_valid) begin
        rsp_port.push_back(0); rsp_cyc.push_back(cyc); rsp_data.push_back(rsp0_rdata); rsp_errq.push_back(rsp0_err);
      end
      if (rsp1_valid) begin
        rsp_port.push_back(1); rsp_cyc.push_back(cyc); rsp_data.push_back(rsp1_rdata); rsp_errq.push_back(rsp1_err);
      end
      if (!rst_n) begin
        chk("reset_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
                              rsp0_err, rsp1_err, ram_din, ram_rx_valid}, 64'd0);
        m_wait = 1'b0; m_free = 0; m_last = 1'b1;
        for (int i = cyc; i < NCYC; i++) begin e_cv[i] = 1'b0; e_rv[i] = 1'b0; end
      end else begin
        er0 = 1'b0; er1 = 1'b0;
        if (m_wait && cyc >= m_wstart) begin
          if (ram_tx_valid) begin
            sched_rsp(cyc + 1, m_g, ram_dout, 1'b0); m_wait = 1'b0;
          end else if (cyc - m_wstart == RD_TIMEOUT - 1) begin
            sched_rsp(cyc + 1, m_g, 8'h00, 1'b1); m_wait = 1'b0;
          end
        end
        if (cyc >= m_free && (req0_valid || req1_valid)) begin
          m_g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
          m_last = m_g;
          er0    = !m_g; er1 = m_g;
          m_we   = m_g ? req1_we : req0_we;
          m_a    = m_g ? req1_addr : req0_addr;
          m_d    = m_g ? req1_wdata : req0_wdata;
          e_cv[cyc+1] = 1'b1; e_din[cyc+1] = {(m_we ? 2'b00 : 2'b10), m_a};
          e_cv[cyc+2] = 1'b1; e_din[cyc+2] = m_we ? {2'b01, m_d} : {2'b11, 8'h00};
          if (m_we) sched_rsp(cyc + 3, m_g, 8'h00, 1'b0);
          else begin m_wait = 1'b1; m_wstart = cyc + 3; m_free = NCYC * 2; end
        end
        exp_cmd = e_cv[cyc] ? e_din[cyc] : 10'h000;
        exp_rsp = 20'h0;
        if (e_rv[cyc]) begin
          if (e_rp[cyc]) exp_rsp = {1'b1, 1'b0, e_re[cyc], 1'b0, e_rd[cyc], 8'h00};
          else           exp_rsp = {1'b0, 1'b1, 1'b0, e_re[cyc], 8'h00, e_rd[cyc]};
        end
        chk("ready", {req1_ready, req0_ready}, {er1, er0});
        chk("ram_cmd", {ram_rx_valid, ram_din}, {e_cv[cyc], exp_cmd});
        chk("rsp", {rsp1_valid, rsp0_valid, rsp1_err, rsp0_err, rsp1_rdata, rsp0_rdata}, exp_rsp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input int p, input bit we, input logic [7:0] a, input logic [7:0] d);
    int n;
    bit ok;
    n  = acc_port.size();
    ok = 1'b0;
    if (p == 0) begin req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d; end
    else        begin req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d; end
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (acc_port.size() > n) begin ok = 1'b1; break; end
    end
    // Scramble the request right after acceptance; it must not leak through.
    if (p == 0) begin req0_valid = 1'b0; req0_we = ~we; req0_addr = 8'hFF; req0_wdata = 8'h5A; end
    else        begin req1_valid = 1'b0; req1_we = ~we; req1_addr = 8'hFF; req1_wdata = 8'h5A; end
    chk("accept_seen", ok, 1);
  endtask

  task automatic wait_rsp(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_port.size() >= n) begin ok = 1'b1; break; end
      tick(1);
    end
    chk("rsp_seen", ok, 1);
  endtask

  initial begin
    #30000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, nr, na;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Write from requester 0
    nd = din_log.size(); nr = rsp_port.size();
    issue(0, 1'b1, 8'h05, 8'hBB);
    wait_rsp(nr + 1);
    chk("wr_din0", din_log[nd], 10'h005);
    chk("wr_din1", din_log[nd+1], 10'h1BB);
    chk("wr_latency", rsp_cyc[nr] - acc_cyc[acc_cyc.size()-1], 3);
    chk("wr_port_err", {rsp_port[nr][0], rsp_errq[nr]}, 2'b00);

    // Read from requester 1, RAM answers one cycle after opcode 11
    ram_mode = 1'b1;
    nd = din_log.size(); nr = rsp_port.size();
    issue(1, 1'b0, 8'h05, 8'h77);
    wait_rsp(nr + 1);
    chk("rd_din0", din_log[nd], 10'h205);
    chk("rd_din1", din_log[nd+1], 10'h300);
    chk("rd_latency", rsp_cyc[nr] - acc_cyc[acc_cyc.size()-1], 4);
    chk("rd_data", {rsp_port[nr][0], rsp_errq[nr], rsp_data[nr]}, {1'b1, 1'b0, 8'hBB});

    // Round robin after a fresh reset, both held valid
    @(posedge clk); #2 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    na = acc_port.size(); nr = rsp_port.size();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h10; req0_wdata = 8'h11;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h20; req1_wdata = 8'h22;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (acc_port.size() >= na + 4) break;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_count", acc_port.size() - na, 4);
    if (acc_port.size() >= na + 4)
      chk("rr_order", {acc_port[na][0], acc_port[na+1][0], acc_port[na+2][0], acc_port[na+3][0]}, 4'b0101);
    wait_rsp(nr + 4);
    chk("rr_back_to_back", acc_cyc[na+1] - acc_cyc[na], 4);

    // Read timeout
    ram_mode = 1'b0;
    nr = rsp_port.size();
    issue(0, 1'b0, 8'h20, 8'h00);
    wait_rsp(nr + 1);
    chk("to_latency", rsp_cyc[nr] - acc_cyc[acc_cyc.size()-1], 3 + RD_TIMEOUT);
    chk("to_data", {rsp_port[nr][0], rsp_errq[nr], rsp_data[nr]}, {1'b0, 1'b1, 8'h00});

    // Reset while waiting for read data
    nr = rsp_port.size();
    issue(1, 1'b0, 8'h10, 8'h00);
    tick(5);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk("rst_immediate", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, ram_din, ram_rx_valid}, 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(25);
    chk("rst_no_rsp", rsp_port.size(), nr);
    ram_mode = 1'b1;
    issue(0, 1'b0, 8'h10, 8'h00);
    wait_rsp(nr + 1);
    chk("post_rst_rd", {rsp_port[nr][0], rsp_errq[nr], rsp_data[nr]}, {1'b0, 1'b0, 8'h11});

    // Spurious RAM strobe while idle
    nr = rsp_port.size();
    spur_dout = 8'hCC; spur_tv = 1'b1;
    tick(2);
    spur_tv = 1'b0;
    tick(2);
    chk("spur_no_rsp", rsp_port.size(), nr);
    issue(1, 1'b0, 8'h20, 8'h00);
    wait_rsp(nr + 1);
    chk("spur_then_rd", {rsp_port[nr][0], rsp_errq[nr], rsp_data[nr]}, {1'b1, 1'b0, 8'h22});

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
